sim_run_control: RTL and testbench

//  Run controller for the CPU: generates ENABLE, the signal that starts and stops the CPU clock generator.
//  CLK is the free-running system/bench clock, not the gated CPU clock.

---
 rtl/sim_run_control_pkg.sv | 21 ++
 rtl/sim_run_control_counter.sv | 36 +++
 rtl/sim_run_control.sv | 117 +++++++++++
 tb/tb_sim_run_control.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_run_control_pkg.sv
// Shared types and defaults for the CPU run controller: state encoding,
// default halt word / watchdog limit, and the drain-counter width helper.
package sim_run_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_HALT_WORD    = 32'hFFFF_FFFF;
  localparam int unsigned DEFAULT_MAX_CYCLES   = 100000;
  localparam int unsigned DEFAULT_DRAIN_CYCLES = 4;

  // A zero-length drain still needs a 1-bit register to keep the port legal.
  function automatic int unsigned drain_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sim_run_control_counter.sv
// Clearable up-counter used for both the cycle and the instruction counts.
module run_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // NOTE: give every always_comb output a default first so no path can leave it
  // unassigned (that would infer a latch); use '=' here and '<=' only in always_ff.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sim_run_control.sv
// CPU run controller: raises ENABLE on START, watches fetched words for the
// halt word, drains the pipeline for DRAIN_CYCLES edges, then stops the clock.
module sim_run_control
  import sim_run_control_pkg::*;
#(
  parameter logic [31:0] HALT_WORD    = DEFAULT_HALT_WORD,
  parameter int unsigned DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int unsigned MAX_CYCLES   = DEFAULT_MAX_CYCLES,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [31:0]      INSTR,
  input  logic             STALL,
  output logic             ENABLE,
  output logic             RUNNING,
  output logic             DONE,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] CYCLE_COUNT,
  output logic [CNT_W-1:0] INSTR_COUNT
);

  localparam int unsigned      DW         = drain_width(DRAIN_CYCLES);
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(MAX_CYCLES - 1);

  state_e        state_q;
  logic [DW-1:0] drain_q;
  logic          enable_q;
  logic          timeout_q;

  logic active;
  logic start_go;
  logic halt_det;
  logic instr_inc;
  logic wd_hit;

  // STALL gates INSTR first, so an undriven word during a stall cannot steer the FSM.
  assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign start_go  = ((state_q == ST_IDLE) || (state_q == ST_HALTED)) && START;
  assign halt_det  = (state_q == ST_RUN) && !STALL && (INSTR == HALT_WORD);
  assign instr_inc = (state_q == ST_RUN) && !STALL && (INSTR != HALT_WORD);
  assign wd_hit    = active && (CYCLE_COUNT == WD_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      drain_q   <= '0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (START) begin
            state_q   <= ST_RUN;
            enable_q  <= 1'b1;
            timeout_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (wd_hit) begin
            state_q   <= ST_HALTED;
            enable_q  <= 1'b0;
            timeout_q <= 1'b1;
          end else if (halt_det) begin
            if (DRAIN_CYCLES == 0) begin
              state_q  <= ST_HALTED;
              enable_q <= 1'b0;
            end else begin
              state_q <= ST_DRAIN;
              drain_q <= DRAIN_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          drain_q <= drain_q - DW'(1);
          // Watchdog wins over a drain that would complete on the same edge.
          if (wd_hit) begin
            state_q   <= ST_HALTED;
            enable_q  <= 1'b0;
            timeout_q <= 1'b1;
          end else if (drain_q == DW'(1)) begin
            state_q  <= ST_HALTED;
            enable_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  run_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (start_go),
    .inc     (active),
    .count_o (CYCLE_COUNT)
  );

  run_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (start_go),
    .inc     (instr_inc),
    .count_o (INSTR_COUNT)
  );

  assign ENABLE  = enable_q;
  assign RUNNING = active;
  assign DONE    = (state_q == ST_HALTED);
  assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_sim_run_control.sv
// Bench for sim_run_control: three configurations driven in lockstep and
// compared edge by edge against a whole-program reference model.
module tb_sim_run_control;

  localparam int          HMAX = 40;
  localparam int          ND   = 3;
  localparam logic [31:0] HW   = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        en;
    logic        run;
    logic        done;
    logic        to;
    logic [31:0] cyc;
    logic [31:0] ic;
  } obs_t;

  // dut0: defaults, dut1: MAX_CYCLES=20, dut2: DRAIN_CYCLES=0
  int cfg_drain [ND] = '{4, 4, 0};
  int cfg_max   [ND] = '{100000, 20, 100000};

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic        STALL;
  logic [31:0] INSTR;

  logic        en_o   [ND];
  logic        run_o  [ND];
  logic        done_o [ND];
  logic        to_o   [ND];
  logic [31:0] cyc_o  [ND];
  logic [31:0] ic_o   [ND];

  logic        stim_stall [0:HMAX];
  logic [31:0] stim_instr [0:HMAX];
  logic        stim_start [0:HMAX];
  obs_t        obs [ND][0:HMAX];

  int n_err = 0;
  int n_chk = 0;

  always #5 CLK = ~CLK;

  sim_run_control u_dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .INSTR(INSTR), .STALL(STALL),
    .ENABLE(en_o[0]), .RUNNING(run_o[0]), .DONE(done_o[0]), .TIMEOUT(to_o[0]),
    .CYCLE_COUNT(cyc_o[0]), .INSTR_COUNT(ic_o[0])
  );

  sim_run_control #(.MAX_CYCLES(20)) u_dut_wd (
    .CLK(CLK), .RST_N(RST_N), .START(START), .INSTR(INSTR), .STALL(STALL),
    .ENABLE(en_o[1]), .RUNNING(run_o[1]), .DONE(done_o[1]), .TIMEOUT(to_o[1]),
    .CYCLE_COUNT(cyc_o[1]), .INSTR_COUNT(ic_o[1])
  );

  sim_run_control #(.DRAIN_CYCLES(0)) u_dut_d0 (
    .CLK(CLK), .RST_N(RST_N), .START(START), .INSTR(INSTR), .STALL(STALL),
    .ENABLE(en_o[2]), .RUNNING(run_o[2]), .DONE(done_o[2]), .TIMEOUT(to_o[2]),
    .CYCLE_COUNT(cyc_o[2]), .INSTR_COUNT(ic_o[2])
  );

  function automatic obs_t get_obs(input int d);
    obs_t o;
    o.en   = en_o[d];
    o.run  = run_o[d];
    o.done = done_o[d];
    o.to   = to_o[d];
    o.cyc  = cyc_o[d];
    o.ic   = ic_o[d];
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("en=%b run=%b done=%b to=%b cyc=%0d ic=%0d",
                     o.en, o.run, o.done, o.to, o.cyc, o.ic);
  endfunction

  // Whole-run view: find the first valid halt word, decide where the run ends
  // (halt + drain, or the watchdog limit if that comes first or at the same
  // time), then read every output after edge j from that end point.
  function automatic obs_t model_at(input int d, input int j);
    obs_t m;
    int   k = 0;
    int   endc;
    int   ic = 0;
    bit   wd;
    for (int i = 1; i <= HMAX; i++)
      if (k == 0 && !stim_stall[i] && stim_instr[i] === HW) k = i;
    if (k != 0 && k + cfg_drain[d] < cfg_max[d]) begin
      endc = k + cfg_drain[d];
      wd   = 1'b0;
    end else begin
      endc = cfg_max[d];
      wd   = 1'b1;
    end
    for (int i = 1; i <= j && i <= endc; i++)
      if (!stim_stall[i] && (k == 0 || i < k)) ic++;
    m.en   = (j < endc);
    m.run  = (j < endc);
    m.done = (j >= endc);
    m.to   = (j >= endc) && wd;
    m.cyc  = (j < endc) ? j : endc;
    m.ic   = ic;
    return m;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HW) w = 32'h0;
    return w;
  endfunction

  task automatic fill_program(input int stall_pct);
    for (int i = 0; i <= HMAX; i++) begin
      stim_stall[i] = ($urandom_range(99) < stall_pct);
      stim_instr[i] = rand_word();
      stim_start[i] = 1'b0;
    end
    stim_stall[0] = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    START = 1'b0;
    STALL = 1'b1;
    INSTR = 'x;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic drive_edge(input int j);
    START = stim_start[j];
    STALL = stim_stall[j];
    if (stim_stall[j]) INSTR = 'x;
    else               INSTR = stim_instr[j];
  endtask

  // START on edge 0, program words on edges 1..h; obs[d][j] = outputs after edge j.
  task automatic run_prog(input int h, input bit do_reset);
    if (do_reset) apply_reset();
    @(negedge CLK);
    START = 1'b1;
    STALL = 1'b1;
    INSTR = 'x;
    for (int j = 1; j <= h; j++) begin
      @(negedge CLK);
      for (int d = 0; d < ND; d++) obs[d][j-1] = get_obs(d);
      drive_edge(j);
    end
    @(negedge CLK);
    for (int d = 0; d < ND; d++) obs[d][h] = get_obs(d);
    START = 1'b0;
    STALL = 1'b1;
    INSTR = 'x;
  endtask

  task automatic test_reset();
    obs_t zero = '0;
    obs_t got;
    RST_N = 1'b0;
    START = 1'b0;
    STALL = 1'b1;
    INSTR = 'x;
    #3;
    for (int d = 0; d < ND; d++) begin
      got = get_obs(d);
      n_chk++;
      if (got !== zero) begin
        n_err++;
        $display("FAIL reset_state dut%0d: got %s want %s", d, fmt(got), fmt(zero));
      end
    end
    @(negedge CLK);
    RST_N = 1'b1;
    STALL = 1'b0;
    INSTR = HW;
    for (int e = 0; e < 3; e++) begin
      @(negedge CLK);
      for (int d = 0; d < ND; d++) begin
        got = get_obs(d);
        n_chk++;
        if (got !== zero) begin
          n_err++;
          $display("FAIL idle_hold dut%0d cyc%0d: got %s want %s", d, e, fmt(got), fmt(zero));
        end
      end
    end
  endtask

  task automatic test_normal_halt();
    obs_t exp_o;
    int   en_cycles = 0;
    fill_program(0);
    stim_instr[11] = HW;
    run_prog(24, 1'b1);
    for (int d = 0; d < ND; d++)
      for (int j = 0; j <= 24; j++) begin
        exp_o = model_at(d, j);
        n_chk++;
        if (obs[d][j] !== exp_o) begin
          n_err++;
          $display("FAIL normal_halt dut%0d edge%0d: got %s want %s", d, j, fmt(obs[d][j]), fmt(exp_o));
        end
      end
    for (int j = 0; j <= 24; j++) if (obs[0][j].en === 1'b1) en_cycles++;
    n_chk++;
    if (en_cycles != 15) begin
      n_err++;
      $display("FAIL normal_enable_len: got %0d cycles want 15", en_cycles);
    end
    n_chk++;
    if (obs[0][24].cyc !== 32'd15 || obs[0][24].ic !== 32'd10 || obs[0][24].done !== 1'b1 || obs[0][24].to !== 1'b0) begin
      n_err++;
      $display("FAIL normal_final: got %s want cyc=15 ic=10 done=1 to=0", fmt(obs[0][24]));
    end
  endtask

  task automatic test_stalls();
    obs_t exp_o;
    fill_program(0);
    for (int i = 3; i <= 5; i++) stim_stall[i] = 1'b1;
    stim_instr[4]  = HW;
    stim_instr[11] = HW;
    run_prog(24, 1'b1);
    for (int d = 0; d < ND; d++)
      for (int j = 0; j <= 24; j++) begin
        exp_o = model_at(d, j);
        n_chk++;
        if (obs[d][j] !== exp_o) begin
          n_err++;
          $display("FAIL stalls dut%0d edge%0d: got %s want %s", d, j, fmt(obs[d][j]), fmt(exp_o));
        end
      end
    n_chk++;
    if (obs[0][24].cyc !== 32'd15 || obs[0][24].ic !== 32'd7 || obs[0][4].run !== 1'b1) begin
      n_err++;
      $display("FAIL stalls_final: got %s (edge4 run=%b) want cyc=15 ic=7 edge4 run=1", fmt(obs[0][24]), obs[0][4].run);
    end
  endtask

  task automatic test_watchdog();
    obs_t exp_o;
    for (int t = 0; t < 5; t++) begin
      fill_program(30);
      if (t == 1) begin
        stim_stall[20] = 1'b0;
        stim_instr[20] = HW;
      end else if (t > 1) begin
        int k = $urandom_range(24, 14);
        stim_stall[k] = 1'b0;
        stim_instr[k] = HW;
      end
      run_prog(30, 1'b1);
      for (int d = 0; d < ND; d++)
        for (int j = 0; j <= 30; j++) begin
          exp_o = model_at(d, j);
          n_chk++;
          if (obs[d][j] !== exp_o) begin
            n_err++;
            $display("FAIL watchdog t%0d dut%0d edge%0d: got %s want %s", t, d, j, fmt(obs[d][j]), fmt(exp_o));
          end
        end
      if (t < 2) begin
        n_chk++;
        if (obs[1][30].cyc !== 32'd20 || obs[1][30].to !== 1'b1 || obs[1][30].en !== 1'b0 || obs[1][19].en !== 1'b1) begin
          n_err++;
          $display("FAIL watchdog_limit t%0d: got %s want cyc=20 to=1 en=0", t, fmt(obs[1][30]));
        end
      end
    end
  endtask

  task automatic test_drain_zero();
    obs_t exp_o;
    fill_program(0);
    stim_instr[1] = HW;
    run_prog(10, 1'b1);
    for (int d = 0; d < ND; d++)
      for (int j = 0; j <= 10; j++) begin
        exp_o = model_at(d, j);
        n_chk++;
        if (obs[d][j] !== exp_o) begin
          n_err++;
          $display("FAIL drain_zero dut%0d edge%0d: got %s want %s", d, j, fmt(obs[d][j]), fmt(exp_o));
        end
      end
    n_chk++;
    if (obs[2][1].done !== 1'b1 || obs[2][10].cyc !== 32'd1 || obs[2][10].ic !== 32'd0 || obs[2][10].to !== 1'b0) begin
      n_err++;
      $display("FAIL drain_zero_final: got %s want cyc=1 ic=0 done=1 to=0", fmt(obs[2][10]));
    end
  endtask

  task automatic test_reset_mid_drain();
    obs_t zero = '0;
    obs_t got;
    obs_t exp_o;
    fill_program(0);
    stim_instr[11] = HW;
    apply_reset();
    @(negedge CLK);
    START = 1'b1;
    STALL = 1'b1;
    INSTR = 'x;
    for (int j = 1; j <= 13; j++) begin
      @(negedge CLK);
      drive_edge(j);
    end
    @(posedge CLK);
    #1;
    got   = get_obs(0);
    exp_o = model_at(0, 13);
    n_chk++;
    if (got !== exp_o) begin
      n_err++;
      $display("FAIL pre_reset_drain: got %s want %s", fmt(got), fmt(exp_o));
    end
    #1;
    RST_N = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      got = get_obs(d);
      n_chk++;
      if (got !== zero) begin
        n_err++;
        $display("FAIL reset_mid_drain dut%0d: got %s want %s", d, fmt(got), fmt(zero));
      end
    end
    @(negedge CLK);
    RST_N = 1'b1;
    START = 1'b0;
    STALL = 1'b0;
    INSTR = rand_word();
    for (int e = 0; e < 4; e++) begin
      @(negedge CLK);
      for (int d = 0; d < ND; d++) begin
        got = get_obs(d);
        n_chk++;
        if (got !== zero) begin
          n_err++;
          $display("FAIL idle_after_reset dut%0d cyc%0d: got %s want %s", d, e, fmt(got), fmt(zero));
        end
      end
    end
    STALL = 1'b1;
    INSTR = 'x;
  endtask

  task automatic test_rerun();
    obs_t exp_o;
    fill_program(0);
    stim_instr[11] = HW;
    run_prog(20, 1'b1);
    n_chk++;
    if (obs[0][20].done !== 1'b1 || obs[0][20].cyc !== 32'd15) begin
      n_err++;
      $display("FAIL rerun_first: got %s want done=1 cyc=15", fmt(obs[0][20]));
    end
    fill_program(25);
    stim_stall[8] = 1'b0;
    stim_instr[8] = HW;
    stim_start[2] = 1'b1;
    stim_start[5] = 1'b1;
    run_prog(20, 1'b0);
    for (int d = 0; d < ND; d++)
      for (int j = 0; j <= 20; j++) begin
        exp_o = model_at(d, j);
        n_chk++;
        if (obs[d][j] !== exp_o) begin
          n_err++;
          $display("FAIL rerun dut%0d edge%0d: got %s want %s", d, j, fmt(obs[d][j]), fmt(exp_o));
        end
      end
    n_chk++;
    if (obs[0][0].done !== 1'b0 || obs[0][0].cyc !== 32'd0 || obs[0][0].ic !== 32'd0 || obs[0][0].en !== 1'b1) begin
      n_err++;
      $display("FAIL rerun_start_edge: got %s want en=1 done=0 cyc=0 ic=0", fmt(obs[0][0]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_normal_halt();
    test_stalls();
    test_watchdog();
    test_drain_zero();
    test_reset_mid_drain();
    test_rerun();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
